// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the MEM stage: FSM states, wait-counter width, SRAM geometry.
// Optional one-entry read buffer in mem_stage is enabled by defining MEM_STAGE_RDBUF_EN.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_DONE
    } mem_state_t;

    localparam int WAIT_CNT_W    = 4;
    localparam int BASE_ADDR_DEF = 1024;
    localparam int SRAM_AW_DEF   = 18;
    localparam int SRAM_DW       = 16;

endpackage

// File: rtl/mem_stage_sram_wait_cnt.sv
// Loadable down-counter timing each half-word SRAM access; last is high when the count reaches zero.
// Latency: load takes effect next cycle. Backpressure: none, free-running once loaded.
// Stalls at zero until reloaded.
module sram_wait_cnt
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    output logic                  last
);

    logic [WAIT_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/mem_stage.sv
// MEM stage driving a 16-bit async SRAM as two half-word accesses per 32-bit word.
// Latency: IDLE + 2*WAIT_CYCLES bus cycles, result in DONE. Backpressure: ready=0 freezes upstream.
// Defining MEM_STAGE_RDBUF_EN adds a one-entry read buffer that answers repeat loads in IDLE.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int BASE_ADDR   = BASE_ADDR_DEF,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               WB_EN_in,
    input  logic               MEM_R_EN_in,
    input  logic               MEM_W_EN_in,
    input  logic [3:0]         Dest_in,
    input  logic [31:0]        ALU_Res_in,
    input  logic [31:0]        Val_Rm_in,
    output logic               WB_EN_out,
    output logic               MEM_R_EN_out,
    output logic [3:0]         Dest_out,
    output logic [31:0]        ALU_Res_out,
    output logic [31:0]        MEM_Res,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [SRAM_DW-1:0] SRAM_DQ_O,
    output logic               SRAM_DQ_OE,
    input  logic [SRAM_DW-1:0] SRAM_DQ_I,
    output logic               SRAM_WE_N
);

    mem_state_t         state, state_nxt;
    logic               req, is_store, hit, cnt_load, cnt_last, bus_act;
    logic [31:0]        offset, res_q, hit_dat;
    logic [SRAM_AW-2:0] word;
    logic               unused_addr_bits;

    assign req      = MEM_R_EN_in | MEM_W_EN_in;
    assign is_store = MEM_W_EN_in;
    assign offset   = ALU_Res_in - 32'(BASE_ADDR);
    assign word     = offset[SRAM_AW:2];
    assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    assign WB_EN_out    = WB_EN_in;
    assign MEM_R_EN_out = MEM_R_EN_in;
    assign Dest_out     = Dest_in;
    assign ALU_Res_out  = ALU_Res_in;

    sram_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst),
        .load     (cnt_load),
        .load_val (WAIT_CNT_W'(WAIT_CYCLES - 1)),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        case (state)
            ST_IDLE: if (req && !hit) begin
                state_nxt = ST_LO;
                cnt_load  = 1'b1;
            end
            ST_LO: if (cnt_last) begin
                state_nxt = ST_HI;
                cnt_load  = 1'b1;
            end
            ST_HI:   if (cnt_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus_act = (state == ST_LO) || (state == ST_HI);
    assign ready   = ~req | (state == ST_DONE) | hit;

    // Strobe released on the last cycle of each half so address/data stay valid past WE_N rising.
    assign SRAM_WE_N  = ~(is_store & bus_act & ~cnt_last);
    assign SRAM_DQ_OE = is_store & bus_act;
    assign SRAM_DQ_O  = (state == ST_HI) ? Val_Rm_in[31:16] : Val_Rm_in[15:0];

    always_comb begin
        SRAM_ADDR = '0;
        case (state)
            ST_LO:   SRAM_ADDR = {word, 1'b0};
            ST_HI:   SRAM_ADDR = {word, 1'b1};
            default: SRAM_ADDR = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q <= '0;
        end else if (hit) begin
            res_q <= hit_dat;
        end else if (!is_store && cnt_last && state == ST_LO) begin
            res_q[15:0] <= SRAM_DQ_I;
        end else if (!is_store && cnt_last && state == ST_HI) begin
            res_q[31:16] <= SRAM_DQ_I;
        end
    end

`ifdef MEM_STAGE_RDBUF_EN
    logic               buf_vld;
    logic [SRAM_AW-2:0] buf_word;
    logic [31:0]        buf_dat;

    assign hit     = MEM_R_EN_in & ~MEM_W_EN_in & (state == ST_IDLE) & buf_vld & (buf_word == word);
    assign hit_dat = buf_dat;
    assign MEM_Res = hit ? buf_dat : res_q;

    // In DONE res_q already holds the full loaded word, so it doubles as the fill data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld  <= 1'b0;
            buf_word <= '0;
            buf_dat  <= '0;
        end else if (state == ST_DONE) begin
            if (!is_store) begin
                buf_vld  <= 1'b1;
                buf_word <= word;
                buf_dat  <= res_q;
            end else if (buf_vld && buf_word == word) begin
                buf_dat <= Val_Rm_in;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_dat = '0;
    assign MEM_Res = res_q;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            assert (!(MEM_R_EN_in && MEM_W_EN_in))
                else $error("mem_stage: load and store requested together, treated as store");
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (W=2, base 1024) with a behavioural 16-bit SRAM model.
// Builds with or without MEM_STAGE_RDBUF_EN; expectations adjust to the build.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [3:0]  Dest_in;
    logic [31:0] ALU_Res_in, Val_Rm_in;
    logic        WB_EN_out, MEM_R_EN_out;
    logic [3:0]  Dest_out;
    logic [31:0] ALU_Res_out, MEM_Res;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_O, SRAM_DQ_I;
    logic        SRAM_DQ_OE, SRAM_WE_N;

    logic [15:0] sram [0:255];

    int tests = 0;
    int fails = 0;

`ifdef MEM_STAGE_RDBUF_EN
    localparam bit RDBUF = 1'b1;
`else
    localparam bit RDBUF = 1'b0;
`endif
    localparam int LOW_FULL = 5;  // one IDLE acceptance cycle + 2 x WAIT_CYCLES bus cycles

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .WB_EN_in     (WB_EN_in),
        .MEM_R_EN_in  (MEM_R_EN_in),
        .MEM_W_EN_in  (MEM_W_EN_in),
        .Dest_in      (Dest_in),
        .ALU_Res_in   (ALU_Res_in),
        .Val_Rm_in    (Val_Rm_in),
        .WB_EN_out    (WB_EN_out),
        .MEM_R_EN_out (MEM_R_EN_out),
        .Dest_out     (Dest_out),
        .ALU_Res_out  (ALU_Res_out),
        .MEM_Res      (MEM_Res),
        .ready        (ready),
        .SRAM_ADDR    (SRAM_ADDR),
        .SRAM_DQ_O    (SRAM_DQ_O),
        .SRAM_DQ_OE   (SRAM_DQ_OE),
        .SRAM_DQ_I    (SRAM_DQ_I),
        .SRAM_WE_N    (SRAM_WE_N)
    );

    assign SRAM_DQ_I = sram[SRAM_ADDR[7:0]];

    always @(posedge clk) begin
        if (!SRAM_WE_N) sram[SRAM_ADDR[7:0]] <= SRAM_DQ_O;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] exp_res;
        logic        buf_hit;
        int          idx;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } vec_t;

    vec_t vecs[$];

    // Present one operation right after a rising edge and follow it until ready rises.
    task automatic run_op(input vec_t v, input int tag);
        int  low, oe_cyc, we_cyc, bad, exp_low, t;
        bit  done;
        WB_EN_in    = v.rd;
        MEM_R_EN_in = v.rd;
        MEM_W_EN_in = v.wr;
        Dest_in     = tag[3:0];
        ALU_Res_in  = v.addr;
        Val_Rm_in   = v.wdat;
        low = 0; oe_cyc = 0; we_cyc = 0; bad = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (SRAM_DQ_OE) oe_cyc++;
            if (!SRAM_WE_N) we_cyc++;
            if (v.rd && (SRAM_DQ_OE || !SRAM_WE_N)) bad++;
            if (ready) done = 1'b1;
            else low++;
        end
        check($sformatf("op%0d_timeout", tag), 32'(done), 32'd1);
        if (!v.rd && !v.wr)      exp_low = 0;
        else if (RDBUF && v.buf_hit) exp_low = 0;
        else                     exp_low = LOW_FULL;
        check($sformatf("op%0d_ready_low_cycles", tag), 32'(low), 32'(exp_low));
        check($sformatf("op%0d_dest_pass", tag), 32'(Dest_out), 32'(tag[3:0]));
        check($sformatf("op%0d_alu_pass", tag), ALU_Res_out, v.addr);
        check($sformatf("op%0d_rden_pass", tag), 32'({WB_EN_out, MEM_R_EN_out}), 32'({v.rd, v.rd}));
        if (v.rd) begin
            check($sformatf("op%0d_mem_res", tag), MEM_Res, v.exp_res);
            check($sformatf("op%0d_load_bus_quiet", tag), 32'(bad), 32'd0);
        end
        if (v.wr) begin
            check($sformatf("op%0d_oe_cycles", tag), 32'(oe_cyc), 32'd4);
            check($sformatf("op%0d_we_cycles", tag), 32'(we_cyc), 32'd2);
            check($sformatf("op%0d_sram_lo", tag), 32'(sram[v.idx]), 32'(v.exp_lo));
            check($sformatf("op%0d_sram_hi", tag), 32'(sram[v.idx+1]), 32'(v.exp_hi));
        end
        if (!v.rd && !v.wr) begin
            t = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (!ready || !SRAM_WE_N || SRAM_ADDR != 18'd0) t++;
            end
            check($sformatf("op%0d_nop_idle_bus", tag), 32'(t), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
        rst = 1'b0;
        WB_EN_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
        Dest_in = 4'd0; ALU_Res_in = 32'd0; Val_Rm_in = 32'd0;

        //         rd    wr    addr        wdat          exp_res       hit   idx lo        hi
        vecs.push_back('{1'b0, 1'b1, 32'd1024,   32'hDEADBEEF, 32'h0,        1'b0, 0, 16'hBEEF, 16'hDEAD});
        vecs.push_back('{1'b1, 1'b0, 32'd1024,   32'h0,        32'hDEADBEEF, 1'b0, 0, 16'h0,    16'h0});
        vecs.push_back('{1'b0, 1'b0, 32'd1024,   32'h0,        32'h0,        1'b0, 0, 16'h0,    16'h0});
        vecs.push_back('{1'b0, 1'b1, 32'd1028,   32'h12345678, 32'h0,        1'b0, 2, 16'h5678, 16'h1234});
        vecs.push_back('{1'b1, 1'b0, 32'd1028,   32'h0,        32'h12345678, 1'b0, 0, 16'h0,    16'h0});
        vecs.push_back('{1'b1, 1'b0, 32'd1026,   32'h0,        32'hDEADBEEF, 1'b0, 0, 16'h0,    16'h0});
        vecs.push_back('{1'b0, 1'b1, 32'd525312, 32'hCAFEF00D, 32'h0,        1'b0, 0, 16'hF00D, 16'hCAFE});
        vecs.push_back('{1'b1, 1'b0, 32'd1024,   32'h0,        32'hCAFEF00D, 1'b1, 0, 16'h0,    16'h0});
        vecs.push_back('{1'b1, 1'b0, 32'd1028,   32'h0,        32'h12345678, 1'b0, 0, 16'h0,    16'h0});
        vecs.push_back('{1'b0, 1'b1, 32'd1032,   32'hA5A55A5A, 32'h0,        1'b0, 4, 16'h5A5A, 16'hA5A5});
        if (RDBUF) begin
            vecs.push_back('{1'b1, 1'b0, 32'd1024, 32'h0, 32'hCAFEF00D, 1'b0, 0, 16'h0,    16'h0});
            vecs.push_back('{1'b1, 1'b0, 32'd1024, 32'h0, 32'hCAFEF00D, 1'b1, 0, 16'h0,    16'h0});
            vecs.push_back('{1'b0, 1'b1, 32'd1024, 32'd5, 32'h0,        1'b0, 0, 16'h0005, 16'h0000});
            vecs.push_back('{1'b1, 1'b0, 32'd1024, 32'h0, 32'd5,        1'b1, 0, 16'h0,    16'h0});
        end

        // Reset state
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        check("rst_oe", 32'(SRAM_DQ_OE), 32'd0);
        check("rst_addr", 32'(SRAM_ADDR), 32'd0);
        check("rst_mem_res", MEM_Res, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Consecutive rows are back-to-back: each starts in the IDLE cycle after the previous DONE.
        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], i);

        // Reset asserted during the HI half of a store
        WB_EN_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b1;
        ALU_Res_in = 32'd1048; Val_Rm_in = 32'h11112222;
        repeat (4) @(negedge clk);
        check("midrst_in_hi_oe", 32'(SRAM_DQ_OE), 32'd1);
        check("midrst_in_hi_addr", 32'(SRAM_ADDR), 32'd13);
        rst = 1'b0;
        #1;
        check("midrst_we_n", 32'(SRAM_WE_N), 32'd1);
        check("midrst_oe", 32'(SRAM_DQ_OE), 32'd0);
        check("midrst_addr", 32'(SRAM_ADDR), 32'd0);
        check("midrst_ready_req_idle", 32'(ready), 32'd0);
        check("midrst_mem_res", MEM_Res, 32'd0);
        MEM_W_EN_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("postrst_ready", 32'(ready), 32'd1);
        check("postrst_hi_untouched", 32'(sram[13]), 32'd0);
        @(posedge clk); #1;

        // Full sequence after reset; any read buffer contents are gone
        v = '{1'b1, 1'b0, 32'd1024, 32'h0, (RDBUF ? 32'd5 : 32'hCAFEF00D), 1'b0, 0, 16'h0, 16'h0};
        run_op(v, 15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
